// File: rtl/pipe_rbs4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_rbs4_pkg
// Description : Shared arithmetic constants for the pipelined ripple-borrow
//               subtractor. Holds the default operand width, the matching
//               pipeline latency, and the offset helper that packs the
//               triangular B-operand skew storage into one flat vector.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_rbs4_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int LATENCY   = DEF_WIDTH;

    // Rank r of the B skew store keeps operand bits [w-1:r+1], i.e. w-1-r
    // bits. Ranks are packed back to back, so rank r starts after the sum
    // of the widths of ranks 0..r-1.
    function automatic int b_off(input int r, input int w);
        return r * (w - 1) - (r * (r - 1)) / 2;
    endfunction

endpackage : pipe_rbs4_pkg
`default_nettype wire

// File: rtl/pipe_rbs4_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_rbs4_if
// Description : Operand/result bundle of the pipelined subtractor.
// Ports       : en        - pipeline advance enable
//               in_valid  - a/b/bin carry a new operation
//               a, b, bin - minuend, subtrahend, borrow in
//               diff      - difference (registered)
//               bout      - borrow out (registered)
//               out_valid - diff/bout hold a valid result
//               master modport drives operands, slave modport is the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_rbs4_if
    import pipe_rbs4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             en;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             out_valid;

    modport master (
        output en, in_valid, a, b, bin,
        input  diff, bout, out_valid
    );

    modport slave (
        input  en, in_valid, a, b, bin,
        output diff, bout, out_valid
    );

endinterface : pipe_rbs4_if
`default_nettype wire

// File: rtl/fullsub.sv
`default_nettype none
// ============================================================================
// Module      : fullsub
// Description : One-bit full subtractor built from gate primitives.
//               d_o  = a ^ b ^ bi
//               bo_o = (~a & b) | (~(a ^ b) & bi)
// Ports       : a_i  - minuend bit
//               b_i  - subtrahend bit
//               bi_i - borrow in
//               d_o  - difference bit
//               bo_o - borrow out
// Revision    : 1.0 - initial release
// ============================================================================
module fullsub (
    input  wire a_i,
    input  wire b_i,
    input  wire bi_i,
    output wire d_o,
    output wire bo_o
);

    wire w_axb;
    wire w_na;
    wire w_nxb;
    wire w_t1;
    wire w_t2;

    xor u_x1 (w_axb, a_i, b_i);
    xor u_x2 (d_o, w_axb, bi_i);
    not u_n1 (w_na, a_i);
    and u_a1 (w_t1, w_na, b_i);
    not u_n2 (w_nxb, w_axb);
    and u_a2 (w_t2, w_nxb, bi_i);
    or  u_o1 (bo_o, w_t1, w_t2);

endmodule : fullsub
`default_nettype wire

// File: rtl/pipe_rbs4.sv
`default_nettype none
// ============================================================================
// Module      : pipe_rbs4
// Description : Bit-serial-in-space pipelined subtractor. An input rank
//               captures A/B/Bin/valid; WIDTH one-bit full-subtractor stages
//               follow, each with its own register rank, so a result leaves
//               the pipe WIDTH enabled edges after capture.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - pipe_rbs4_if slave modport (operands in, result out)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_rbs4
    import pipe_rbs4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire        clk,
    input  wire        rst_n,
    pipe_rbs4_if.slave bus
);

    // Total B skew storage: rank r holds WIDTH-1-r pending subtrahend bits.
    localparam int B_BITS = (WIDTH * (WIDTH - 1)) / 2;

    // Input capture rank.
    logic [WIDTH-1:0] in_a_q;
    logic [WIDTH-1:0] in_b_q;
    logic             in_bin_q;
    logic             in_v_q;

    // Per stage rank r: word bits [r:0] are finished difference bits and
    // bits [WIDTH-1:r+1] are minuend bits not yet consumed, so the word is
    // fully used in every rank.
    logic [WIDTH-1:0] word_q [WIDTH];
    logic [WIDTH-1:0] word_d [WIDTH];
    logic [WIDTH-1:0] bo_q;
    logic [WIDTH-1:0] bo_d;
    logic [WIDTH-1:0] v_q;
    logic [WIDTH-1:0] v_d;
    logic [B_BITS-1:0] bsk_q;
    logic [B_BITS-1:0] bsk_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        localparam logic [WIDTH-1:0] c_mask = WIDTH'(1) << i;

        wire              w_a;
        wire              w_b;
        wire              w_bi;
        wire              w_d;
        wire [WIDTH-1:0]  w_word_prev;

        if (i == 0) begin : g_first
            assign w_a         = in_a_q[0];
            assign w_b         = in_b_q[0];
            assign w_bi        = in_bin_q;
            assign w_word_prev = in_a_q;
            assign v_d[0]      = in_v_q;
        end else begin : g_rest
            assign w_a         = word_q[i-1][i];
            // Bit i is the lowest pending bit of rank i-1.
            assign w_b         = bsk_q[b_off(i - 1, WIDTH)];
            assign w_bi        = bo_q[i-1];
            assign w_word_prev = word_q[i-1];
            assign v_d[i]      = v_q[i-1];
        end

        fullsub u_fullsub (
            .a_i  (w_a),
            .b_i  (w_b),
            .bi_i (w_bi),
            .d_o  (w_d),
            .bo_o (bo_d[i])
        );

        // Replace the consumed minuend bit with the freshly computed
        // difference bit; all other bits just shift down one rank.
        assign word_d[i] = (w_word_prev & ~c_mask) | ({WIDTH{w_d}} & c_mask);

        // The last rank has no pending subtrahend bits.
        if (i < WIDTH - 1) begin : g_bskew
            if (i == 0) begin : g_from_in
                assign bsk_d[b_off(0, WIDTH) +: WIDTH-1] = in_b_q[WIDTH-1:1];
            end else begin : g_from_rank
                assign bsk_d[b_off(i, WIDTH) +: WIDTH-1-i] =
                    bsk_q[b_off(i - 1, WIDTH) + 1 +: WIDTH-1-i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_a_q   <= '0;
            in_b_q   <= '0;
            in_bin_q <= 1'b0;
            in_v_q   <= 1'b0;
            for (int r = 0; r < WIDTH; r++) begin
                word_q[r] <= '0;
            end
            bo_q     <= '0;
            v_q      <= '0;
            bsk_q    <= '0;
        end else if (bus.en) begin
            in_a_q   <= bus.a;
            in_b_q   <= bus.b;
            in_bin_q <= bus.bin;
            in_v_q   <= bus.in_valid;
            for (int r = 0; r < WIDTH; r++) begin
                word_q[r] <= word_d[r];
            end
            bo_q     <= bo_d;
            v_q      <= v_d;
            bsk_q    <= bsk_d;
        end
    end

    assign bus.diff      = word_q[WIDTH-1];
    assign bus.bout      = bo_q[WIDTH-1];
    assign bus.out_valid = v_q[WIDTH-1];

endmodule : pipe_rbs4
`default_nettype wire
